// File: rtl/sync_detect.sv
// sync_detect: hsync/vsync edge detector, line/frame measurer and
// timing-mode classifier with a confirm/miss lock state machine.
//
// Ports:
//   clk28        sole clock (rising edge)
//   rst          synchronous active-high reset
//   hsync_n      async active-low horizontal sync
//   vsync_n      async active-low vertical sync
//   hs_fall      1-cycle pulse per hsync falling edge
//   vs_fall      1-cycle pulse per vsync falling edge
//   line_len     cycles between the last two hs_fall pulses
//   frame_lines  hs_fall count of the last complete frame
//   rx_hc        cycles since last hs_fall, divided by 4
//   rx_vc        hs_fall count since last vs_fall
//   locked       timing mode confirmed
//   timings      detected mode (held while unlocked)

package sync_detect_pkg;
    typedef enum logic [1:0] {
        TIMINGS_S48  = 2'd0,
        TIMINGS_S128 = 2'd1,
        TIMINGS_PENT = 2'd2
    } timings_t;
endpackage

module sync_detect
    import sync_detect_pkg::*;
#(
    parameter int LEN_TOL  = 4,
    parameter int MISS_MAX = 2
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic        hs_fall,
    output logic        vs_fall,
    output logic [11:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [9:0]  rx_hc,
    output logic [9:0]  rx_vc,
    output logic        locked,
    output timings_t    timings
);

    localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CANDIDATE,
        ST_LOCKED
    } state_t;

    // {history, stage2, stage1}
    logic [2:0]    hs_sh;
    logic [2:0]    vs_sh;
    logic [11:0]   cyc_cnt;
    logic [9:0]    line_cnt;
    logic          len_ok;
    logic          frm_ok;
    logic [MW-1:0] miss;
    state_t        state;
    timings_t      cand;

    logic          hs_edge;
    logic          vs_edge;
    logic [11:0]   cyc_nxt;
    logic [9:0]    line_inc;
    logic [9:0]    line_nxt;
    logic [11:0]   len_nxt;
    logic [9:0]    frm_nxt;
    logic          cls_evt;
    logic          to_cyc;
    logic          to_line;
    logic          n1792;
    logic          n1824;
    logic          cls_known;
    timings_t      cls;
    logic [MW:0]   miss_inc;

    function automatic logic near(input logic [11:0] v,
                                  input logic [11:0] nom);
        logic [11:0] d;
        d = (v >= nom) ? (v - nom) : (nom - v);
        return d <= 12'(LEN_TOL);
    endfunction

    assign hs_edge = hs_sh[2] & ~hs_sh[1];
    assign vs_edge = vs_sh[2] & ~vs_sh[1];
    assign rx_hc   = cyc_cnt[11:2];
    assign rx_vc   = line_cnt;

    always_comb begin
        cyc_nxt  = cyc_cnt;
        line_inc = line_cnt;
        if (hs_fall)
            cyc_nxt = 12'd1;
        else if (cyc_cnt != 12'hFFF)
            cyc_nxt = cyc_cnt + 12'd1;
        if (hs_fall && line_cnt != 10'h3FF)
            line_inc = line_cnt + 10'd1;
        // A coincident hs_fall closes the old frame, not the new one.
        line_nxt = vs_fall ? 10'd0 : line_inc;
        len_nxt  = (hs_fall && len_ok) ? cyc_cnt : line_len;
        frm_nxt  = (vs_fall && frm_ok) ? line_inc : frame_lines;
        cls_evt  = vs_fall && frm_ok && len_ok;
        to_cyc   = (cyc_nxt == 12'hFFF);
        to_line  = !vs_fall && (line_nxt == 10'h3FF);
        miss_inc = {1'b0, miss} + (MW + 1)'(1);
    end

    always_comb begin
        n1792     = near(len_nxt, 12'd1792);
        n1824     = near(len_nxt, 12'd1824);
        cls       = TIMINGS_PENT;
        cls_known = 1'b0;
        unique case (1'b1)
            n1792 && frm_nxt == 10'd312: begin
                cls       = TIMINGS_S48;
                cls_known = 1'b1;
            end
            n1824 && frm_nxt == 10'd311: begin
                cls       = TIMINGS_S128;
                cls_known = 1'b1;
            end
            n1792 && frm_nxt == 10'd320: begin
                cls       = TIMINGS_PENT;
                cls_known = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            hs_sh       <= 3'b111;
            vs_sh       <= 3'b111;
            hs_fall     <= 1'b0;
            vs_fall     <= 1'b0;
            cyc_cnt     <= 12'd0;
            line_cnt    <= 10'd0;
            line_len    <= 12'd0;
            frame_lines <= 10'd0;
            len_ok      <= 1'b0;
            frm_ok      <= 1'b0;
            miss        <= '0;
            state       <= ST_UNLOCKED;
            cand        <= TIMINGS_PENT;
            timings     <= TIMINGS_PENT;
            locked      <= 1'b0;
        end else begin
            hs_sh       <= {hs_sh[1:0], hsync_n};
            vs_sh       <= {vs_sh[1:0], vsync_n};
            hs_fall     <= hs_edge;
            vs_fall     <= vs_edge;
            cyc_cnt     <= cyc_nxt;
            line_cnt    <= line_nxt;
            line_len    <= len_nxt;
            frame_lines <= frm_nxt;
            if (hs_fall)
                len_ok <= 1'b1;
            if (vs_fall)
                frm_ok <= 1'b1;
            if (to_cyc) begin
                len_ok <= 1'b0;
                frm_ok <= 1'b0;
            end
            if (to_line)
                frm_ok <= 1'b0;

            if (to_cyc || to_line) begin
                state  <= ST_UNLOCKED;
                locked <= 1'b0;
                miss   <= '0;
            end else if (cls_evt) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (cls_known) begin
                            state <= ST_CANDIDATE;
                            cand  <= cls;
                        end
                    end
                    ST_CANDIDATE: begin
                        if (!cls_known) begin
                            state <= ST_UNLOCKED;
                        end else if (cls == cand) begin
                            state   <= ST_LOCKED;
                            locked  <= 1'b1;
                            timings <= cand;
                            miss    <= '0;
                        end else begin
                            cand <= cls;
                        end
                    end
                    ST_LOCKED: begin
                        if (cls_known && cls == timings) begin
                            miss <= '0;
                        end else if (miss_inc >= (MW + 1)'(MISS_MAX)) begin
                            state  <= ST_UNLOCKED;
                            locked <= 1'b0;
                            miss   <= '0;
                        end else begin
                            miss <= miss_inc[MW-1:0];
                        end
                    end
                    default: begin
                        state  <= ST_UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
